// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
//
// Bit-parallel half adder with WIDTH independent lanes. Each lane computes
// sum = a ^ b and carry = a & b. There is no carry chain between lanes.
//
// Two views of the same result are provided:
//   - S / C     : combinational, zero latency, independent of clk/rst/in_valid.
//   - S_q / C_q : one-stage registered copy, captured when in_valid is high,
//                 qualified by out_valid (registered in_valid).
//
// Optional feature (compile-time macro HALF_ADDER_CARRY_CNT_EN):
//   - Adds output carry_cnt[15:0]. It counts the accepted cycles
//     (in_valid=1) in which at least one lane generates a carry. The counter
//     saturates at 16'hFFFF and is cleared asynchronously by rst.
//   - When the macro is undefined, the port and its logic are absent.
//
// Parameters:
//   WIDTH      number of lanes, legal range 1..64
//
// Ports:
//   clk        rising-edge clock for the registered path
//   rst        asynchronous active-high reset for the registered path
//   A, B       operands, one bit per lane
//   in_valid   qualifies A/B for capture into the registered path
//   S, C       combinational sum / carry
//   S_q, C_q   registered sum / carry (hold when in_valid=0)
//   out_valid  high for one cycle after each capture
//   carry_cnt  (optional) saturating count of accepted carry-generating cycles
// -----------------------------------------------------------------------------
module half_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] S_q,
  output logic [WIDTH-1:0] C_q,
`ifdef HALF_ADDER_CARRY_CNT_EN
  output logic [15:0]      carry_cnt,
`endif
  output logic             out_valid
);

  // Combinational lanes: each bit position is an isolated half adder.
  always_comb begin
    S = A ^ B;
    C = A & B;
  end

  // Registered copy. The result registers only load on an accepted cycle,
  // so they keep the last captured result while out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_q       <= '0;
      C_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S_q <= S;
        C_q <= C;
      end
    end
  end

`ifdef HALF_ADDER_CARRY_CNT_EN
  logic any_carry;

  always_comb begin
    any_carry = |C;
  end

  // Saturating counter: stops at all-ones instead of wrapping to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt <= '0;
    end else if (in_valid && any_carry && (carry_cnt != '1)) begin
      carry_cnt <= carry_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// -----------------------------------------------------------------------------
// tb_half_adder
//
// Directed-vector bench for half_adder. Two instances share clk/rst/in_valid:
// a scalar (WIDTH=1) one and an 8-lane one. Expected values are written out
// by hand from the half-adder truth table.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [0:0] a1, b1;
  logic [0:0] s1, c1, s1_q, c1_q;
  logic       ov1;
  logic [7:0] a8, b8;
  logic [7:0] s8, c8, s8_q, c8_q;
  logic       ov8;
`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [15:0] cnt1, cnt8;
`endif

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .A         (a1),
    .B         (b1),
    .in_valid  (in_valid),
    .S         (s1),
    .C         (c1),
    .S_q       (s1_q),
    .C_q       (c1_q),
`ifdef HALF_ADDER_CARRY_CNT_EN
    .carry_cnt (cnt1),
`endif
    .out_valid (ov1)
  );

  half_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .A         (a8),
    .B         (b8),
    .in_valid  (in_valid),
    .S         (s8),
    .C         (c8),
    .S_q       (s8_q),
    .C_q       (c8_q),
`ifdef HALF_ADDER_CARRY_CNT_EN
    .carry_cnt (cnt8),
`endif
    .out_valid (ov8)
  );

  // Scalar combinational truth table: ab:sc = 00:00, 01:10, 10:10, 11:01.
  task automatic test_comb();
    logic [1:0] ab_vec [4];
    logic [1:0] sc_exp [4];
    ab_vec = '{2'b00, 2'b01, 2'b10, 2'b11};
    sc_exp = '{2'b00, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      a1 = ab_vec[i][1];
      b1 = ab_vec[i][0];
      #1;
      tests_run++;
      if ({s1, c1} !== sc_exp[i]) begin
        tests_failed++;
        $display("FAIL comb_truth ab=%b: sc got %b expected %b",
                 ab_vec[i], {s1, c1}, sc_exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    // Reset held from time zero: registered outputs are 0.
    rst = 1'b1;
    in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    @(posedge clk); #1;
    tests_run++;
    if ({s1_q, c1_q, ov1} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_held: {s_q,c_q,ov} got %b expected 000", {s1_q, c1_q, ov1});
    end
    // Combinational path keeps tracking during reset.
    tests_run++;
    if ({s1, c1} !== 2'b10) begin
      tests_failed++;
      $display("FAIL comb_in_reset: sc got %b expected 10", {s1, c1});
    end
    // Release, capture S_q=1.
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({s1_q, c1_q, ov1} !== 3'b101) begin
      tests_failed++;
      $display("FAIL first_capture: {s_q,c_q,ov} got %b expected 101", {s1_q, c1_q, ov1});
    end
    // Asynchronous reset between edges clears immediately.
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({s1_q, c1_q, ov1} !== 3'b000) begin
      tests_failed++;
      $display("FAIL async_reset: {s_q,c_q,ov} got %b expected 000", {s1_q, c1_q, ov1});
    end
    // Deassert with in_valid=0: nothing captured.
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({s1_q, c1_q, ov1} !== 3'b000) begin
      tests_failed++;
      $display("FAIL post_reset_idle: {s_q,c_q,ov} got %b expected 000", {s1_q, c1_q, ov1});
    end
  endtask

  task automatic test_latency();
    @(negedge clk); a1 = 1'b1; b1 = 1'b1; in_valid = 1'b1;
    tests_run++;
    if (ov1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_pre_edge: ov got %b expected 0", ov1);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({s1_q, c1_q, ov1} !== 3'b011) begin
      tests_failed++;
      $display("FAIL latency_capture: {s_q,c_q,ov} got %b expected 011", {s1_q, c1_q, ov1});
    end
    @(negedge clk); a1 = 1'b0; b1 = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({s1_q, c1_q, ov1} !== 3'b010) begin
      tests_failed++;
      $display("FAIL latency_hold: {s_q,c_q,ov} got %b expected 010", {s1_q, c1_q, ov1});
    end
  endtask

  task automatic test_lanes();
    @(negedge clk); a8 = 8'hF0; b8 = 8'hCC; in_valid = 1'b1;
    #1;
    tests_run++;
    if ({s8, c8} !== {8'h3C, 8'hC0}) begin
      tests_failed++;
      $display("FAIL lanes_f0_cc: s,c got %h,%h expected 3c,c0", s8, c8);
    end
    tests_run++;
    if ((s8 & c8) !== 8'h00) begin
      tests_failed++;
      $display("FAIL lanes_invariant: s&c got %h expected 00", s8 & c8);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({s8_q, c8_q, ov8} !== {8'h3C, 8'hC0, 1'b1}) begin
      tests_failed++;
      $display("FAIL lanes_reg: s_q,c_q,ov got %h,%h,%b expected 3c,c0,1", s8_q, c8_q, ov8);
    end
    @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; in_valid = 1'b0;
    #1;
    tests_run++;
    if ({s8, c8} !== {8'h00, 8'hFF}) begin
      tests_failed++;
      $display("FAIL lanes_ff_ff: s,c got %h,%h expected 00,ff", s8, c8);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({s8_q, c8_q, ov8} !== {8'h3C, 8'hC0, 1'b0}) begin
      tests_failed++;
      $display("FAIL lanes_reg_hold: s_q,c_q,ov got %h,%h,%b expected 3c,c0,0", s8_q, c8_q, ov8);
    end
    a8 = 8'h00; b8 = 8'h00;
  endtask

  task automatic test_back_to_back();
    logic [1:0] ab_vec [4];
    logic [1:0] sc_exp [4];
    ab_vec = '{2'b00, 2'b01, 2'b10, 2'b11};
    sc_exp = '{2'b00, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = ab_vec[i][1]; b1 = ab_vec[i][0]; in_valid = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if ({s1_q, c1_q, ov1} !== {sc_exp[i], 1'b1}) begin
        tests_failed++;
        $display("FAIL b2b_%0d: {s_q,c_q,ov} got %b expected %b",
                 i, {s1_q, c1_q, ov1}, {sc_exp[i], 1'b1});
      end
    end
    @(negedge clk); in_valid = 1'b0; a1 = 1'b0; b1 = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({s1_q, c1_q, ov1} !== 3'b010) begin
      tests_failed++;
      $display("FAIL b2b_end: {s_q,c_q,ov} got %b expected 010", {s1_q, c1_q, ov1});
    end
  endtask

`ifdef HALF_ADDER_CARRY_CNT_EN
  task automatic test_carry_cnt();
    logic [1:0] ab_vec [5];
    ab_vec = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b11};
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a1 = ab_vec[i][1]; b1 = ab_vec[i][0]; in_valid = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0; a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (cnt1 !== 16'd3) begin
      tests_failed++;
      $display("FAIL carry_cnt: got %0d expected 3", cnt1);
    end
    tests_run++;
    if (cnt8 !== 16'd0) begin
      tests_failed++;
      $display("FAIL carry_cnt_no_carry: got %0d expected 0", cnt8);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (cnt1 !== 16'd0) begin
      tests_failed++;
      $display("FAIL carry_cnt_reset: got %0d expected 0", cnt1);
    end
    @(negedge clk); rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a1 = 1'b0; b1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    test_comb();
    test_reset();
    test_latency();
    test_lanes();
    test_back_to_back();
`ifdef HALF_ADDER_CARRY_CNT_EN
    test_carry_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
